// File: rtl/riscv_ifq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : riscv_ifq                                                     |
// | Purpose  : Instruction fetch queue between the fetch unit's AXI read     |
// |            path and decode. Buffers in-order {pc, instr, err} responses, |
// |            grants issue credit from occupancy plus requests in flight,   |
// |            and discards stale responses after a flush.                   |
// | Ports    : clock, reset (async, active-low)                              |
// |            req_issue, issue_ok          - fetch request credit           |
// |            fetch_vld/pc/data/err        - response word in               |
// |            dec_vld/pc/instr/err, dec_rdy- head entry out to decode       |
// |            flush                        - discard queue and in-flight    |
// |            count, ovf                   - occupancy, sticky overflow     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module riscv_ifq #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_issue,
  output logic          issue_ok,
  input  logic          fetch_vld,
  input  logic [31:0]   fetch_pc,
  input  logic [31:0]   fetch_data,
  input  logic          fetch_err,
  output logic          dec_vld,
  output logic [31:0]   dec_pc,
  output logic [31:0]   dec_instr,
  output logic          dec_err,
  input  logic          dec_rdy,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic          ovf
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  logic [31:0]   r_mem_pc    [DEPTH];
  logic [31:0]   r_mem_instr [DEPTH];
  logic          r_mem_err   [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop_cnt;
  logic          r_ovf;

  logic          w_dropping;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [CW:0]   w_credit;

  // Acceptance depends only on registered occupancy: a pop in the same
  // cycle never frees room for a push, so dec_rdy has no path to acceptance.
  assign w_dropping = (r_drop_cnt != '0);
  assign w_full     = (r_count == c_depth);
  assign w_push     = fetch_vld && !w_dropping && !w_full && !flush;
  assign w_pop      = (r_count != '0) && dec_rdy && !flush;

  // Credit counts responses already owed to us, so the queue always has room.
  assign w_credit   = {1'b0, r_count} + {1'b0, r_inflight};
  assign issue_ok   = (w_credit < {1'b0, c_depth});

  assign dec_vld    = (r_count != '0);
  assign dec_pc     = r_mem_pc[r_rd_ptr];
  assign dec_instr  = r_mem_instr[r_rd_ptr];
  assign dec_err    = r_mem_err[r_rd_ptr];
  assign count      = r_count;
  assign ovf        = r_ovf;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]    <= '0;
        r_mem_instr[i] <= '0;
        r_mem_err[i]   <= 1'b0;
      end
    end else if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= fetch_pc;
      r_mem_instr[r_wr_ptr] <= fetch_data;
      r_mem_err[r_wr_ptr]   <= fetch_err;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop_cnt <= '0;
      r_ovf      <= 1'b0;
    end else begin
      // Every response retires one in-flight request, dropped or not.
      r_inflight <= r_inflight + CW'(req_issue) - CW'(fetch_vld);

      if (fetch_vld && !w_dropping && w_full && !flush) begin
        r_ovf <= 1'b1;
      end

      if (flush) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        // Everything still owed belongs to the old stream; a request issued
        // this cycle is new-stream and deliberately not counted here.
        r_drop_cnt <= r_inflight - CW'(fetch_vld);
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + CW'(1);
        end else if (!w_push && w_pop) begin
          r_count <= r_count - CW'(1);
        end
        if (fetch_vld && w_dropping) begin
          r_drop_cnt <= r_drop_cnt - CW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_ifq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_riscv_ifq                                                  |
// | Purpose  : Directed self-checking bench for riscv_ifq (DEPTH=4).         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_riscv_ifq;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_issue = 1'b0;
  logic        issue_ok;
  logic        fetch_vld = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic [31:0] fetch_data = '0;
  logic        fetch_err = 1'b0;
  logic        dec_vld;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic        dec_err;
  logic        dec_rdy = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  count;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] instr_tbl [4] = '{32'h13, 32'h93, 32'h113, 32'h193};

  riscv_ifq #(.DEPTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_issue  (req_issue),
    .issue_ok   (issue_ok),
    .fetch_vld  (fetch_vld),
    .fetch_pc   (fetch_pc),
    .fetch_data (fetch_data),
    .fetch_err  (fetch_err),
    .dec_vld    (dec_vld),
    .dec_pc     (dec_pc),
    .dec_instr  (dec_instr),
    .dec_err    (dec_err),
    .dec_rdy    (dec_rdy),
    .flush      (flush),
    .count      (count),
    .ovf        (ovf)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (dec_vld !== 1'b0) begin n_fail++; $display("FAIL rst_dec_vld: got %b want 0", dec_vld); end
    n_checks++; if (dec_pc !== 32'h0) begin n_fail++; $display("FAIL rst_dec_pc: got %h want 0", dec_pc); end
    n_checks++; if (dec_instr !== 32'h0) begin n_fail++; $display("FAIL rst_dec_instr: got %h want 0", dec_instr); end
    n_checks++; if (dec_err !== 1'b0) begin n_fail++; $display("FAIL rst_dec_err: got %b want 0", dec_err); end
    n_checks++; if (issue_ok !== 1'b1) begin n_fail++; $display("FAIL rst_issue_ok: got %b want 1", issue_ok); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Four responses streamed with dec_rdy=1: each visible one cycle after push.
  task automatic test_back_to_back();
    req_issue = 1'b1;
    repeat (4) tick();
    req_issue = 1'b0;
    n_checks++; if (issue_ok !== 1'b0) begin n_fail++; $display("FAIL b2b_credit: got %b want 0", issue_ok); end
    dec_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch_vld  = 1'b1;
      fetch_pc   = 32'h200 + 32'(4 * i);
      fetch_data = instr_tbl[i];
      tick();
      n_checks++; if (dec_vld !== 1'b1) begin n_fail++; $display("FAIL b2b_vld[%0d]: got %b want 1", i, dec_vld); end
      n_checks++; if (dec_pc !== 32'h200 + 32'(4 * i)) begin n_fail++; $display("FAIL b2b_pc[%0d]: got %h want %h", i, dec_pc, 32'h200 + 32'(4 * i)); end
      n_checks++; if (dec_instr !== instr_tbl[i]) begin n_fail++; $display("FAIL b2b_instr[%0d]: got %h want %h", i, dec_instr, instr_tbl[i]); end
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want 1", i, count); end
    end
    fetch_vld = 1'b0;
    tick();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL b2b_drain_count: got %0d want 0", count); end
    n_checks++; if (dec_vld !== 1'b0) begin n_fail++; $display("FAIL b2b_drain_vld: got %b want 0", dec_vld); end
    n_checks++; if (issue_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_drain_credit: got %b want 1", issue_ok); end
    dec_rdy = 1'b0;
  endtask

  // Credit exhaustion, full queue with head held stable, credit back after pop.
  task automatic test_full_hold();
    dec_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_issue = 1'b1;
      tick();
      n_checks++; if (issue_ok !== (i < 3)) begin n_fail++; $display("FAIL full_credit[%0d]: got %b want %b", i, issue_ok, (i < 3)); end
    end
    req_issue = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fetch_vld  = 1'b1;
      fetch_pc   = 32'h200 + 32'(4 * i);
      fetch_data = instr_tbl[i];
      tick();
      n_checks++; if (count !== 3'(i + 1)) begin n_fail++; $display("FAIL full_count[%0d]: got %0d want %0d", i, count, i + 1); end
      n_checks++; if (issue_ok !== 1'b0) begin n_fail++; $display("FAIL full_credit_fill[%0d]: got %b want 0", i, issue_ok); end
    end
    fetch_vld = 1'b0;
    n_checks++; if (dec_vld !== 1'b1) begin n_fail++; $display("FAIL full_vld: got %b want 1", dec_vld); end
    n_checks++; if (dec_pc !== 32'h200) begin n_fail++; $display("FAIL full_head_pc: got %h want 00000200", dec_pc); end
    tick();
    tick();
    n_checks++; if (dec_pc !== 32'h200) begin n_fail++; $display("FAIL full_hold_pc: got %h want 00000200", dec_pc); end
    n_checks++; if (dec_instr !== 32'h13) begin n_fail++; $display("FAIL full_hold_instr: got %h want 00000013", dec_instr); end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_hold_count: got %0d want 4", count); end
    dec_rdy = 1'b1;
    tick();
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_pop_count: got %0d want 3", count); end
    n_checks++; if (issue_ok !== 1'b1) begin n_fail++; $display("FAIL full_pop_credit: got %b want 1", issue_ok); end
    n_checks++; if (dec_pc !== 32'h204) begin n_fail++; $display("FAIL full_pop_pc: got %h want 00000204", dec_pc); end
    repeat (3) tick();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL full_drain: got %0d want 0", count); end
    dec_rdy = 1'b0;
  endtask

  // Flush with two old responses outstanding plus one new-stream request.
  task automatic test_flush();
    req_issue = 1'b1;
    repeat (3) tick();
    req_issue = 1'b0;
    fetch_vld = 1'b1; fetch_pc = 32'h300; fetch_data = 32'h33;
    tick();
    fetch_vld = 1'b0;
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 1", count); end
    flush = 1'b1; req_issue = 1'b1;
    tick();
    flush = 1'b0; req_issue = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", count); end
    n_checks++; if (dec_vld !== 1'b0) begin n_fail++; $display("FAIL flush_vld: got %b want 0", dec_vld); end
    for (int i = 0; i < 2; i++) begin
      fetch_vld = 1'b1; fetch_pc = 32'h304 + 32'(4 * i); fetch_data = 32'hBAD;
      tick();
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_drop[%0d]: got count %0d want 0", i, count); end
    end
    fetch_vld = 1'b1; fetch_pc = 32'h400; fetch_data = 32'h13;
    tick();
    fetch_vld = 1'b0;
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL flush_new_count: got %0d want 1", count); end
    n_checks++; if (dec_pc !== 32'h400) begin n_fail++; $display("FAIL flush_new_pc: got %h want 00000400", dec_pc); end
    n_checks++; if (issue_ok !== 1'b1) begin n_fail++; $display("FAIL flush_new_credit: got %b want 1", issue_ok); end
    dec_rdy = 1'b1;
    tick();
    dec_rdy = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_pop: got %0d want 0", count); end
  endtask

  // Flush colliding with response, new request and pop at count=2.
  task automatic test_flush_collision();
    req_issue = 1'b1;
    repeat (4) tick();
    req_issue = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fetch_vld = 1'b1; fetch_pc = 32'h500 + 32'(4 * i); fetch_data = 32'h55;
      tick();
    end
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL coll_pre_count: got %0d want 2", count); end
    // inflight=2 here; flush cycle: +1 issue -1 response -> inflight 2, drop 1
    flush = 1'b1; req_issue = 1'b1; dec_rdy = 1'b1; fetch_pc = 32'h508;
    tick();
    flush = 1'b0; req_issue = 1'b0; dec_rdy = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL coll_count: got %0d want 0", count); end
    n_checks++; if (issue_ok !== 1'b1) begin n_fail++; $display("FAIL coll_credit: got %b want 1", issue_ok); end
    fetch_pc = 32'h50C;
    tick();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL coll_drop: got count %0d want 0", count); end
    fetch_pc = 32'h600; fetch_data = 32'h66;
    tick();
    fetch_vld = 1'b0;
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL coll_new_count: got %0d want 1", count); end
    n_checks++; if (dec_pc !== 32'h600) begin n_fail++; $display("FAIL coll_new_pc: got %h want 00000600", dec_pc); end
    dec_rdy = 1'b1;
    tick();
    dec_rdy = 1'b0;
  endtask

  // Error flag travels only with its own entry.
  task automatic test_err();
    req_issue = 1'b1;
    repeat (3) tick();
    req_issue = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fetch_vld = 1'b1; fetch_pc = 32'h200 + 32'(4 * i); fetch_data = instr_tbl[i];
      fetch_err = (i == 2);
      tick();
    end
    fetch_vld = 1'b0; fetch_err = 1'b0;
    dec_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (dec_pc !== 32'h200 + 32'(4 * i)) begin n_fail++; $display("FAIL err_pc[%0d]: got %h want %h", i, dec_pc, 32'h200 + 32'(4 * i)); end
      n_checks++; if (dec_err !== (i == 2)) begin n_fail++; $display("FAIL err_flag[%0d]: got %b want %b", i, dec_err, (i == 2)); end
      tick();
    end
    dec_rdy = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL err_drain: got %0d want 0", count); end
  endtask

  // Overflow on a full queue despite a same-cycle pop, then async reset.
  task automatic test_ovf_reset();
    req_issue = 1'b1;
    repeat (4) tick();
    req_issue = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fetch_vld = 1'b1; fetch_pc = 32'h200 + 32'(4 * i); fetch_data = instr_tbl[i];
      tick();
    end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_pre: got %b want 0", ovf); end
    fetch_pc = 32'h700; fetch_data = 32'h77; dec_rdy = 1'b1;
    tick();
    fetch_vld = 1'b0; dec_rdy = 1'b0;
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", ovf); end
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL ovf_count: got %0d want 3", count); end
    n_checks++; if (dec_pc !== 32'h204) begin n_fail++; $display("FAIL ovf_head: got %h want 00000204", dec_pc); end
    tick();
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL async_ovf: got %b want 0", ovf); end
    n_checks++; if (dec_vld !== 1'b0) begin n_fail++; $display("FAIL async_vld: got %b want 0", dec_vld); end
    n_checks++; if (issue_ok !== 1'b1) begin n_fail++; $display("FAIL async_credit: got %b want 1", issue_ok); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL async_count: got %0d want 0", count); end
    n_checks++; if (dec_pc !== 32'h0) begin n_fail++; $display("FAIL async_pc: got %h want 0", dec_pc); end
    tick();
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full_hold();
    test_flush();
    test_flush_collision();
    test_err();
    test_ovf_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_ifq.md
# riscv_ifq

Instruction fetch queue sitting directly downstream of the instruction fetch unit. It accepts in-order instruction-word responses returned over the fetch unit's AXI read path, buffers them with their PCs, and presents them to decode with a valid/ready handshake. It tracks fetch requests in flight so it can grant issue credit to the fetch unit, and it discards stale responses after a pipeline flush.

## Interface
Parameters:
- DEPTH, 4, number of queue entries; power of two, ≥2
- CW, $clog2(DEPTH+1), width of occupancy and in-flight counters

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset; all state cleared while low
- req_issue  in  1  fetch unit had a read request accepted this cycle (its req_ack)
- issue_ok  out  1  fetch unit may issue another request
- fetch_vld  in  1  response word valid this cycle
- fetch_pc  in  32  PC of the response word
- fetch_data  in  32  instruction word (RDATA)
- fetch_err  in  1  response error (RRESP not OKAY)
- dec_vld  out  1  head entry valid
- dec_pc  out  32  head entry PC
- dec_instr  out  32  head entry instruction
- dec_err  out  1  head entry error flag
- dec_rdy  in  1  decode consumes the head this cycle when dec_vld=1
- flush  in  1  redirect: discard queue contents and all responses in flight
- count  out  CW  current occupancy, 0..DEPTH
- ovf  out  1  sticky: response arrived while the queue was full

## Operation
- Storage: circular buffer of DEPTH entries {pc, instr, err}, with wr_ptr, rd_ptr (log2 DEPTH bits, natural wrap), and count.
- Push: fetch_vld=1, drop_cnt=0, count<DEPTH, flush=0. Writes the entry at wr_ptr and advances wr_ptr.
- Pop: dec_vld=1, dec_rdy=1, flush=0. Advances rd_ptr.
- Push and pop in the same cycle leaves count unchanged. A push when count==DEPTH is rejected even if a pop occurs that cycle. In that case the word is lost and ovf is set. No combinational path from dec_rdy to acceptance.
- In-flight counter inflight: inflight_next = inflight + req_issue − fetch_vld. It decrements on every response, including dropped ones.
- issue_ok = (count + inflight) < DEPTH, computed in CW+1 bits. Because of this credit, a correctly behaving fetch unit never overflows the queue.
- Drop counter drop_cnt: while drop_cnt>0, each fetch_vld decrements drop_cnt and the word is discarded, not pushed.
- Flush (flush=1):
  - count, wr_ptr, and rd_ptr are cleared.
  - drop_cnt_next = inflight − fetch_vld, so every response belonging to the pre-flush stream is dropped.
  - A fetch_vld in the flush cycle is discarded.
  - A req_issue in the flush cycle belongs to the new stream. It increments inflight but not drop_cnt.
  - Flush wins over a same-cycle push and pop.
  - Flush while drop_cnt>0: drop_cnt is recomputed per the rule above. No accumulation error is possible because responses return in order.
- ovf: set on fetch_vld && drop_cnt==0 && count==DEPTH && !flush. Cleared only by reset.
- Counter saturation is not required. inflight never exceeds DEPTH under correct credit use.

## Timing
- Reset (reset=0, asynchronous) values:
  - count=0, inflight=0, drop_cnt=0, pointers=0, storage=0, ovf=0.
  - Outputs: dec_vld=0, dec_pc=0, dec_instr=0, dec_err=0, issue_ok=1.
- Reset deassertion is synchronised externally. The first push is possible on the first rising edge after reset goes high.
- Push latency: a word pushed at edge N is visible on dec_* with dec_vld=1 after edge N, i.e. in cycle N+1. There is no same-cycle bypass.
- dec_vld = (count≠0). dec_* are driven from the entry at rd_ptr and are stable while dec_vld=1 && dec_rdy=0.
- Back-to-back: with dec_rdy held at 1 and one response per cycle, throughput is one instruction per cycle at occupancy 1.
- issue_ok, count, and ovf depend only on registered state.
- Reset mid-operation clears everything immediately, including responses in flight. Any later fetch_vld from the old stream is the fetch unit's responsibility, since it is reset by the same signal.

## Test plan
- Reset, then 4 responses with PC 0x200..0x20C and instructions 0x13, 0x93, 0x113, 0x193, dec_rdy=1 → decode sees the same 4 pairs in order, one per cycle, each one cycle after its push; count returns to 0.
- DEPTH=4, dec_rdy=0, issue 4 requests → issue_ok falls to 0 after the 4th issue. Return 4 responses → count=4, dec_vld=1 with PC 0x200 held stable. Raise dec_rdy → issue_ok returns to 1 after the first pop.
- 3 requests issued, 1 response returned, then flush → count=0 next cycle, drop_cnt=2. The next 2 responses are discarded. A request issued in the flush cycle returns with PC 0x400, which is pushed and appears on dec_pc.
- Flush in the same cycle as fetch_vld, req_issue, and a pop at count=2 → count=0, drop_cnt=inflight−1, inflight unchanged (+1−1), and the response is discarded.
- Force fetch_vld with count=4 and dec_rdy=1 → word rejected, ovf=1 and sticky, count=3 after the pop. Assert reset low → ovf=0, dec_vld=0, issue_ok=1 immediately, without waiting for a clock edge.
- Response with fetch_err=1 at PC 0x208 → dec_err=1 only on the entry with dec_pc=0x208.
